// File: rtl/fft_stage8_butterfly_pkg.sv
// Shared constants and FSM encoding for the radix-2 FFT butterfly stage.
package fft_stage8_butterfly_pkg;
    localparam int FFT_DATA_W  = 16;
    localparam int FFT_TW_W    = 14;
    localparam int FFT_PAIRS   = 128;
    localparam int FFT_TW_FRAC = 12;
    localparam int FFT_PTR_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fft_state_e;
endpackage

// File: rtl/fft_cmul_round.sv
// Complex multiply T = B * (cos - j*sin) with round-half-up to DATA_W+1 bits.
// Register 1 aligns B with the ROM output; register 2 holds the full-precision products.
module fft_cmul_round
    import fft_stage8_butterfly_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int TW_W   = FFT_TW_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_b_i,
    input  logic                     ld_p_i,
    input  logic signed [DATA_W-1:0] b_re_i,
    input  logic signed [DATA_W-1:0] b_im_i,
    input  logic signed [TW_W-1:0]   cos_i,
    input  logic signed [TW_W-1:0]   sin_i,
    output logic signed [DATA_W:0]   t_re_o,
    output logic signed [DATA_W:0]   t_im_o
);
    localparam int P_W = DATA_W + TW_W;
    localparam int S_W = P_W + 1;
    localparam int T_W = DATA_W + 1;
    localparam logic signed [S_W-1:0] ROUND = S_W'(1 << (FFT_TW_FRAC - 1));

    logic signed [DATA_W-1:0] b_re_q, b_im_q;
    logic signed [P_W-1:0]    p_rc_q, p_is_q, p_ic_q, p_rs_q;
    logic signed [S_W-1:0]    sum_re, sum_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_re_q <= '0;
            b_im_q <= '0;
            p_rc_q <= '0;
            p_is_q <= '0;
            p_ic_q <= '0;
            p_rs_q <= '0;
        end else begin
            if (ld_b_i) begin
                b_re_q <= b_re_i;
                b_im_q <= b_im_i;
            end
            if (ld_p_i) begin
                p_rc_q <= P_W'(b_re_q) * P_W'(cos_i);
                p_is_q <= P_W'(b_im_q) * P_W'(sin_i);
                p_ic_q <= P_W'(b_im_q) * P_W'(cos_i);
                p_rs_q <= P_W'(b_re_q) * P_W'(sin_i);
            end
        end
    end

    // |W| <= 1 keeps the rounded result inside DATA_W+1 bits, so a plain cast is safe.
    always_comb begin
        sum_re = S_W'(p_rc_q) + S_W'(p_is_q) + ROUND;
        sum_im = S_W'(p_ic_q) - S_W'(p_rs_q) + ROUND;
        t_re_o = T_W'(sum_re >>> FFT_TW_FRAC);
        t_im_o = T_W'(sum_im >>> FFT_TW_FRAC);
    end
endmodule

// File: rtl/fft_stage8_butterfly.sv
// One radix-2 DIT butterfly stage: X = A + B*W, Y = A - B*W, three-cycle pipeline.
// Handshake: a pair is taken on any cycle with in_valid=1 while in RUN (no backpressure).
module fft_stage8_butterfly
    import fft_stage8_butterfly_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int TW_W   = FFT_TW_W,
    parameter int PAIRS  = FFT_PAIRS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   in_a_re,
    input  logic signed [DATA_W-1:0]   in_a_im,
    input  logic signed [DATA_W-1:0]   in_b_re,
    input  logic signed [DATA_W-1:0]   in_b_im,
    output logic [FFT_PTR_W-1:0]       rd_ptr_angle,
    output logic                       tw_en,
    input  logic signed [TW_W-1:0]     cos_data,
    input  logic signed [TW_W-1:0]     sin_data,
    output logic                       out_valid,
    output logic signed [DATA_W+1:0]   out_x_re,
    output logic signed [DATA_W+1:0]   out_x_im,
    output logic signed [DATA_W+1:0]   out_y_re,
    output logic signed [DATA_W+1:0]   out_y_im,
    output logic                       busy,
    output logic                       frame_done,
    output fft_state_e                 dbg_state
);
    localparam int O_W = DATA_W + 2;

    fft_state_e               state_q, state_d;
    logic [FFT_PTR_W-1:0]     cnt_q, cnt_d;
    logic                     accept, last_pair;
    logic                     v1_q, last1_q, v2_q, last2_q, v3_q, fd_q;
    logic signed [DATA_W-1:0] a1_re_q, a1_im_q, a2_re_q, a2_im_q;
    logic signed [DATA_W:0]   t_re, t_im;
    logic signed [O_W-1:0]    x_re_q, x_im_q, y_re_q, y_im_q;
    logic signed [O_W-1:0]    x_re_d, x_im_d, y_re_d, y_im_d;

    assign accept    = (state_q == ST_RUN) && in_valid;
    assign last_pair = (cnt_q == FFT_PTR_W'(PAIRS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    cnt_d = last_pair ? '0 : cnt_q + 1'b1;
                    if (last_pair) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fd_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    fft_cmul_round #(.DATA_W(DATA_W), .TW_W(TW_W)) u_cmul (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld_b_i (accept),
        .ld_p_i (v1_q),
        .b_re_i (in_b_re),
        .b_im_i (in_b_im),
        .cos_i  (cos_data),
        .sin_i  (sin_data),
        .t_re_o (t_re),
        .t_im_o (t_im)
    );

    // Two guard bits absorb the worst case |A| + |T| without wrap.
    always_comb begin
        x_re_d = {{2{a2_re_q[DATA_W-1]}}, a2_re_q} + {t_re[DATA_W], t_re};
        x_im_d = {{2{a2_im_q[DATA_W-1]}}, a2_im_q} + {t_im[DATA_W], t_im};
        y_re_d = {{2{a2_re_q[DATA_W-1]}}, a2_re_q} - {t_re[DATA_W], t_re};
        y_im_d = {{2{a2_im_q[DATA_W-1]}}, a2_im_q} - {t_im[DATA_W], t_im};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            v3_q    <= 1'b0;
            fd_q    <= 1'b0;
            a1_re_q <= '0;
            a1_im_q <= '0;
            a2_re_q <= '0;
            a2_im_q <= '0;
            x_re_q  <= '0;
            x_im_q  <= '0;
            y_re_q  <= '0;
            y_im_q  <= '0;
        end else begin
            v1_q    <= accept;
            last1_q <= accept && last_pair;
            v2_q    <= v1_q;
            last2_q <= last1_q;
            v3_q    <= v2_q;
            fd_q    <= v2_q && last2_q;
            if (accept) begin
                a1_re_q <= in_a_re;
                a1_im_q <= in_a_im;
            end
            if (v1_q) begin
                a2_re_q <= a1_re_q;
                a2_im_q <= a1_im_q;
            end
            if (v2_q) begin
                x_re_q <= x_re_d;
                x_im_q <= x_im_d;
                y_re_q <= y_re_d;
                y_im_q <= y_im_d;
            end
        end
    end

    assign rd_ptr_angle = cnt_q;
    assign tw_en        = accept;
    assign out_valid    = v3_q;
    assign frame_done   = fd_q;
    assign busy         = (state_q != ST_IDLE);
    assign out_x_re     = x_re_q;
    assign out_x_im     = x_im_q;
    assign out_y_re     = y_re_q;
    assign out_y_im     = y_im_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_fft_stage8_butterfly.sv
// Bench for fft_stage8_butterfly: directed vector table plus random frames,
// twiddle ROM model, and an expected-result queue checked at the outputs.
module tb_fft_stage8_butterfly;
    import fft_stage8_butterfly_pkg::*;

    localparam int DW = 16;
    localparam int TWW = 14;
    localparam int OW = 18;
    localparam int NP = 128;
    localparam int NV = 8;
    localparam int DAT_W = 4 * OW;
    localparam int EW = 32 + 1 + DAT_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic signed [DW-1:0] in_a_re = '0, in_a_im = '0, in_b_re = '0, in_b_im = '0;
    logic [6:0] rd_ptr_angle;
    logic tw_en;
    logic signed [TWW-1:0] cos_data = '0, sin_data = '0;
    logic out_valid, busy, frame_done;
    logic signed [OW-1:0] out_x_re, out_x_im, out_y_re, out_y_im;
    fft_state_e dbg_state;

    fft_stage8_butterfly dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
        .rd_ptr_angle(rd_ptr_angle), .tw_en(tw_en),
        .cos_data(cos_data), .sin_data(sin_data),
        .out_valid(out_valid), .out_x_re(out_x_re), .out_x_im(out_x_im),
        .out_y_re(out_y_re), .out_y_im(out_y_im),
        .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Twiddle ROM model: registered read one cycle after tw_en
    int cos_tab [NP];
    int sin_tab [NP];
    always @(posedge clk) begin
        if (tw_en) begin
            cos_data <= TWW'(cos_tab[rd_ptr_angle]);
            sin_data <= TWW'(sin_tab[rd_ptr_angle]);
        end
    end

    typedef struct {
        int ar, ai, br, bi, cs, sn;
        int xr, xi, yr, yi;
    } vec_t;
    vec_t vecs [NV];

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic exp_run = 1'b0;
    int exp_cnt = 0;
    int ov_count = 0;
    int fd_count = 0;
    logic [DAT_W-1:0] last_data = '0;
    logic prev_fd = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [DAT_W-1:0] model(input int ar, ai, br, bi, cs, sn);
        longint tr, ti;
        tr = (longint'(br) * cs + longint'(bi) * sn + 2048) >>> 12;
        ti = (longint'(bi) * cs - longint'(br) * sn + 2048) >>> 12;
        return {OW'(ar + tr), OW'(ai + ti), OW'(ar - tr), OW'(ai - ti)};
    endfunction

    function automatic logic [DAT_W-1:0] pack_exp(input vec_t v);
        return {OW'(v.xr), OW'(v.xi), OW'(v.yr), OW'(v.yi)};
    endfunction

    // Driver: one cycle of stimulus, with acceptance-cycle checks
    task automatic drive(input logic v, input logic st, input int ar, ai, br, bi, cs, sn,
                         input logic use_given, input logic [DAT_W-1:0] given);
        logic [DAT_W-1:0] d;
        logic fd;
        @(negedge clk);
        start    = st;
        in_valid = v;
        in_a_re  = DW'(ar);
        in_a_im  = DW'(ai);
        in_b_re  = DW'(br);
        in_b_im  = DW'(bi);
        if (exp_run && v) begin
            cos_tab[exp_cnt] = cs;
            sin_tab[exp_cnt] = sn;
        end
        #1;
        if (exp_run && v) begin
            check("tw_en_accept", tw_en, 1);
            check("rd_ptr_angle", rd_ptr_angle, exp_cnt);
            d  = use_given ? given : model(ar, ai, br, bi, cs, sn);
            fd = (exp_cnt == NP - 1);
            exp_q.push_back({32'(cyc + 3), fd, d});
            if (fd) begin
                exp_run = 1'b0;
                exp_cnt = 0;
            end else begin
                exp_cnt++;
            end
        end else begin
            check("tw_en_quiet", tw_en, 0);
        end
        if (st && !exp_run && exp_q.size() == 0) exp_run = 1'b1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, '0);
    endtask

    function automatic int rnd_s16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic run_frame(input int n, input int maxgap, input logic use_tab, input int restart_at);
        drive(1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 1'b0, '0);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, maxgap)) idle_cycle();
            if (use_tab && i < NV)
                drive(1'b1, i == restart_at, vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi,
                      vecs[i].cs, vecs[i].sn, 1'b1, pack_exp(vecs[i]));
            else
                drive(1'b1, i == restart_at, rnd_s16(), rnd_s16(), rnd_s16(), rnd_s16(),
                      int'($urandom_range(0, 5792)) - 2896, int'($urandom_range(0, 5792)) - 2896,
                      1'b0, '0);
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            idle_cycle();
            budget--;
        end
        idle_cycle();
        idle_cycle();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", out_valid, 0);
        check("rst_tw_en", tw_en, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_rd_ptr", rd_ptr_angle, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_x_re", out_x_re, 0);
        check("rst_x_im", out_x_im, 0);
        check("rst_y_re", out_y_re, 0);
        check("rst_y_im", out_y_im, 0);
    endtask

    // Scoreboard / monitor, sampled 1 ns after the active edge
    always @(posedge clk) begin
        logic [EW-1:0] e;
        #1;
        if (rst_n) begin
            if (prev_fd) check("busy_after_done", busy, 0);
            prev_fd = frame_done;
            if (frame_done) fd_count++;
            if (out_valid) begin
                ov_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid actual=1 required=0 (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", cyc, longint'(e[EW-1:DAT_W+1]));
                    check("frame_done", frame_done, e[DAT_W]);
                    if (frame_done) check("busy_at_done", busy, 1);
                    last_data = e[DAT_W-1:0];
                    check("x_re", out_x_re, $signed(last_data[4*OW-1:3*OW]));
                    check("x_im", out_x_im, $signed(last_data[3*OW-1:2*OW]));
                    check("y_re", out_y_re, $signed(last_data[2*OW-1:OW]));
                    check("y_im", out_y_im, $signed(last_data[OW-1:0]));
                end
            end else begin
                check("frame_done_quiet", frame_done, 0);
                check("hold_x_re", out_x_re, $signed(last_data[4*OW-1:3*OW]));
                check("hold_y_im", out_y_im, $signed(last_data[OW-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{100, 0, 200, 0, 4096, 0, 300, 0, -100, 0};
        vecs[1] = '{0, 0, 4096, 0, 3895, 1265, 3895, -1265, -3895, 1265};
        vecs[2] = '{32767, 32767, 32767, 32767, 2896, 2896, 79102, 32767, -13568, 32767};
        vecs[3] = '{-32768, -32768, -32768, -32768, 4096, 0, -65536, -65536, 0, 0};
        vecs[4] = '{5, 7, 1000, -2000, 0, 4096, -1995, -993, 2005, 1007};
        vecs[5] = '{0, 0, 3, 0, 2048, 0, 2, 0, -2, 0};
        vecs[6] = '{0, 0, -3, 0, 2048, 0, -1, 0, 1, 0};
        vecs[7] = '{10, 10, 100, 50, -4096, 0, -90, -40, 110, 60};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // in_valid while idle is ignored
        drive(1'b1, 1'b0, 1, 2, 3, 4, 0, 0, 1'b0, '0);
        idle_cycle();

        // Frame 1: directed table then random pairs, random gaps, start re-pulsed at pair 10
        run_frame(NP, 2, 1'b1, 10);
        wait_drain();
        check("frame1_out_valid_count", ov_count, NP);
        check("frame1_frame_done_count", fd_count, 1);
        check("frame1_idle_state", dbg_state, ST_IDLE);

        // Frame 2: reset asserted at pair 60
        run_frame(60, 1, 1'b0, -1);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        exp_q.delete();
        exp_run   = 1'b0;
        exp_cnt   = 0;
        last_data = '0;
        prev_fd   = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, k, k, k, k, 4096, 0, 1'b0, '0);
        repeat (4) idle_cycle();

        // Frame 3: back-to-back pairs after recovery
        ov_count = 0;
        fd_count = 0;
        run_frame(NP, 0, 1'b0, -1);
        wait_drain();
        check("frame3_out_valid_count", ov_count, NP);
        check("frame3_frame_done_count", fd_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
